// File: rtl/deck_builder.sv
// Builds an ordered card deck as a linked list by issuing one add op per card to ram_controller.
// Optional macro JOKERS_EN appends two jokers (value 0, suits 0 then 1) after the 52 standard cards.
module deck_builder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [1:0]  ADD_OP         = 2'd0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  deck_head,
    output logic [5:0]  cards_added,
    output logic        rc_enable,
    output logic [1:0]  rc_select_op,
    output logic [9:0]  rc_arg1,
    output logic [9:0]  rc_arg2,
    input  logic        rc_finished_op,
    input  logic [31:0] rc_out1
);

    // state     | meaning
    // IDLE      | waiting for start
    // ISSUE     | present card/tail, raise rc_enable, clear ack timer
    // WAIT_ACK  | hold request until controller drops finished_op (or time out)
    // WAIT_DONE | wait for controller to finish, capture new card address
    // CHECK     | link new card, count it, pick next card or finish
    // DONE      | one-cycle completion pulse
    // ERR       | timeout or null address; waits for a fresh start
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CHECK, DONE, ERR
    } state_t;

`ifdef JOKERS_EN
    localparam logic [5:0] FINAL_COUNT = 6'd54;
`else
    localparam logic [5:0] FINAL_COUNT = 6'd52;
`endif
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic [1:0]      suit, suit_adv;
    logic [3:0]      value, value_adv;
    logic [9:0]      tail;
    logic [9:0]      addr_cap;
    logic [TW-1:0]   timer, timer_inc;
    logic [5:0]      count_inc;
    logic            start_build;
    logic            unused_out1_hi;

    assign timer_inc      = timer + 1'b1;
    assign count_inc      = cards_added + 6'd1;
    assign unused_out1_hi = ^rc_out1[31:10];

    assign busy         = (state == ISSUE) || (state == WAIT_ACK) ||
                          (state == WAIT_DONE) || (state == CHECK);
    assign done         = (state == DONE);
    assign error        = (state == ERR);
    assign rc_enable    = (state == ISSUE) || (state == WAIT_ACK);
    assign rc_select_op = busy ? ADD_OP : 2'd0;
    assign rc_arg1      = busy ? {4'b0, suit, value} : 10'd0;
    assign rc_arg2      = busy ? tail : 10'd0;

    always_comb begin
        state_next  = state;
        start_build = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    start_build = 1'b1;
                    state_next  = ISSUE;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            ISSUE:     state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (!rc_finished_op)
                    state_next = WAIT_DONE;
                else if (timer_inc == TIMEOUT_LAST)
                    state_next = ERR;
            end
            WAIT_DONE: if (rc_finished_op) state_next = CHECK;
            CHECK: begin
                if (addr_cap == 10'd0)
                    state_next = ERR;
                else if (count_inc == FINAL_COUNT)
                    state_next = DONE;
                else
                    state_next = ISSUE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        suit_adv  = suit;
        value_adv = value + 4'd1;
        if (value == 4'd13) begin
            value_adv = 4'd1;
            suit_adv  = suit + 2'd1;
        end
`ifdef JOKERS_EN
        // After the king of the last suit the jokers follow as value 0, suits 0 and 1.
        if (value == 4'd13 && suit == 2'd3) begin
            value_adv = 4'd0;
            suit_adv  = 2'd0;
        end else if (value == 4'd0) begin
            value_adv = 4'd0;
            suit_adv  = suit + 2'd1;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            suit        <= 2'd0;
            value       <= 4'd1;
            tail        <= 10'd0;
            deck_head   <= 10'd0;
            cards_added <= 6'd0;
            timer       <= '0;
            addr_cap    <= 10'd0;
        end else begin
            if (start_build) begin
                suit        <= 2'd0;
                value       <= 4'd1;
                tail        <= 10'd0;
                deck_head   <= 10'd0;
                cards_added <= 6'd0;
            end
            case (state)
                ISSUE:     timer <= '0;
                WAIT_ACK:  timer <= timer_inc;
                WAIT_DONE: if (rc_finished_op) addr_cap <= rc_out1[9:0];
                CHECK: begin
                    if (addr_cap != 10'd0) begin
                        tail        <= addr_cap;
                        cards_added <= count_inc;
                        if (cards_added == 6'd0)
                            deck_head <= addr_cap;
                        if (count_inc != FINAL_COUNT) begin
                            suit  <= suit_adv;
                            value <= value_adv;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/deck_builder.md
Name: deck_builder

Overview:
- Upstream command sequencer for ram_controller: on start, issues one add-card operation per card to build a fresh ordered 52-card deck as a linked list in card RAM.
- Returns the head address of the new list to the game FSM.
- Owns the enable/finished_op handshake with the controller, including an acknowledge timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for rc_finished_op to fall after rc_enable is raised.
- ADD_OP, 2'd0: select_op encoding of the add operation in ram_controller.

Ports:
- clock  input  1  system clock; all state on posedge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a deck build; sampled only in IDLE, DONE, ERR.
- busy  output  1  high from accepted start until DONE/ERR entered.
- done  output  1  one-cycle pulse when the last card's add completes.
- error  output  1  level; high in ERR until next accepted start or reset.
- deck_head  output  10  address of first card added; valid when done pulses, held until next start.
- cards_added  output  6  count of completed adds; saturates at final count.
- rc_enable  output  1  operation request to ram_controller.
- rc_select_op  output  2  always ADD_OP while busy, 0 otherwise.
- rc_arg1  output  10  {4'b0, suit[1:0], value[3:0]}.
- rc_arg2  output  10  list tail address to append after; 0 means start new list.
- rc_finished_op  input  1  controller idle/finished flag (high when idle).
- rc_out1  input  32  controller result; bits [9:0] = address of newly added card.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; internal suit=0, value=1, tail=0, timeout counter=0.
- Card order: suit 0..3 outer, value 1..13 inner (ace=1, king=13). Final count 52, or 54 with the optional feature.
- States:
  - IDLE: start=1 -> clear counters, tail=0, deck_head=0, busy=1 -> ISSUE. start=0 -> stay.
  - ISSUE: drive rc_arg1/rc_arg2 from current card/tail; rc_enable=1; timeout counter=0 -> WAIT_ACK.
  - WAIT_ACK: hold rc_enable=1 and args stable. rc_finished_op=0 -> rc_enable=0 -> WAIT_DONE. Otherwise increment counter; counter reaches TIMEOUT_CYCLES-1 -> ERR.
  - WAIT_DONE: args stay stable. rc_finished_op=1 -> capture rc_out1[9:0] -> CHECK. No timeout in this state (list walks are unbounded).
  - CHECK: captured address==0 (null) -> ERR. Else tail=addr; if cards_added==0, deck_head=addr; cards_added+1. If new count equals final count -> DONE, else advance card -> ISSUE.
  - Card advance: value==13 -> value=1, suit+1; else value+1.
  - DONE: done=1 for exactly the entry cycle; busy=0. start=1 -> restart as from IDLE; otherwise -> IDLE on the following cycle.
  - ERR: busy=0, error=1, rc_enable=0, cards_added frozen. start=1 -> clear error, restart as from IDLE.
- start while busy is ignored, with no effect on sequence or outputs.
- rc_enable is never high outside ISSUE/WAIT_ACK; at most one outstanding operation.
- Per card, minimum latency is 4 cycles plus controller time (ISSUE, WAIT_ACK, WAIT_DONE, CHECK).
- rc_finished_op already low on ISSUE entry (controller still busy): treated as acknowledge; the bench must not rely on this, and the controller guarantees idle.
- Reset mid-operation: rc_enable drops asynchronously; the partial list in RAM is abandoned, and no cleanup is performed.

Optional Feature:
- Macro JOKERS_EN.
- Defined: after the 52 standard cards, append two jokers: value 0 suit 0, then value 0 suit 1. Final count 54; done fires after the 54th add.
- Undefined: final count 52; value 0 is never issued.

Test Plan:
- Basic build: controller model acks in 2 cycles, completes in 5 cycles, returns addresses 32, 64, 96, ... -> 52 adds in order; first rc_arg1=0x001, rc_arg2=0; second rc_arg1=0x002, rc_arg2=32; 14th rc_arg1=0x011; done pulses once; deck_head=32; cards_added=52.
- Ack timeout: rc_finished_op held high forever after start -> rc_enable high exactly TIMEOUT_CYCLES cycles, then error=1, busy=0, cards_added=0.
- Null address: model returns 0 on the 10th add -> error=1, cards_added=9, no done pulse.
- Start while busy and restart: pulse start during card 5 -> ignored, 52 cards still issued. Start asserted in the done cycle -> second build begins with rc_arg2=0.
- Async reset mid-build: resetn low during WAIT_DONE of card 20 -> rc_enable, busy, cards_added, deck_head all 0 in the same cycle; a subsequent start builds a clean 52-card deck.
- JOKERS_EN: full build -> cards 53 and 54 have rc_arg1=0x000 and 0x010; done after 54; cards_added=54.
